ha_result_buffer: RTL and testbench

//  - Downstream stage of the half-adder wrapper; consumes its registered result bus (valid_out/data_bus_out).
//  - Source has no backpressure, so results are buffered in a DEPTH-entry FIFO and replayed on a valid/ready port.
//  - Tracks accepted-result count and drops on overflow; optionally self-checks each result against a^b / a&b.

---
 rtl/ha_pkg.sv | 23 ++
 rtl/ha_result_buffer_if.sv | 33 +++
 rtl/ha_result_check.sv | 44 ++++
 rtl/ha_result_buffer.sv | 100 ++++++++++
 tb/tb_ha_result_buffer.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/ha_pkg.sv
// Shared half-adder result types: packed {s,c,b,a} result word and the reference
// function that derives the expected sum/carry from a and b.
package ha_pkg;

  localparam int HA_RESULT_W = 4;

  typedef struct packed {
    logic s;
    logic c;
    logic b;
    logic a;
  } ha_result_t;

  function automatic ha_result_t ha_expected(input logic a, input logic b);
    ha_result_t r;
    r.s = a ^ b;
    r.c = a & b;
    r.b = b;
    r.a = a;
    return r;
  endfunction

endpackage

// File: rtl/ha_result_buffer_if.sv
// Result-bus interface between the half-adder source, the result buffer and its consumer.
// The slave modport is the buffer; the master modport is the surrounding environment.
interface ha_result_buffer_if
  import ha_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
);

  logic                     in_valid;
  logic [HA_RESULT_W-1:0]   in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [HA_RESULT_W-1:0]   out_data;
  logic                     full;
  logic                     empty;
  logic [$clog2(DEPTH):0]   level;
  logic                     overflow;
  logic [CNT_W-1:0]         result_cnt;
  logic                     err;
  logic [CNT_W-1:0]         err_cnt;

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data, full, empty, level, overflow, result_cnt, err, err_cnt
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data, full, empty, level, overflow, result_cnt, err, err_cnt
  );

endinterface

// File: rtl/ha_result_check.sv
// Compares each accepted half-adder result against a^b / a&b; keeps a sticky
// error flag and a saturating failure count.
module ha_result_check
  import ha_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             chk_valid_i,
  input  ha_result_t       result_i,
  output logic             err_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  ha_result_t       exp_res;
  logic             mismatch;
  logic             err_q, err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    exp_res   = ha_expected(result_i.a, result_i.b);
    mismatch  = chk_valid_i && ((result_i.s != exp_res.s) || (result_i.c != exp_res.c));
    err_d     = err_q | mismatch;
    err_cnt_d = err_cnt_q;
    if (mismatch && !(&err_cnt_q)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_o     = err_q;
  assign err_cnt_o = err_cnt_q;

endmodule

// File: rtl/ha_result_buffer.sv
// Show-ahead FIFO buffering half-adder results for a valid/ready consumer, with
// overflow tracking and result counting. Optional checker enabled by HA_RESULT_CHECK_EN.
module ha_result_buffer
  import ha_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  ha_result_buffer_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  ha_result_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] result_cnt_q, result_cnt_d;
  logic             full, empty, push, pop;

  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);
  assign pop   = !empty && bus.out_ready;
  // A full FIFO still accepts a new result when the head leaves in the same cycle.
  assign push  = bus.in_valid && (!full || pop);

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    overflow_d   = overflow_q | (bus.in_valid & ~push);
    result_cnt_d = result_cnt_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (!(&result_cnt_q)) begin
        result_cnt_d = result_cnt_q + CNT_W'(1);
      end
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      overflow_q   <= 1'b0;
      result_cnt_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      overflow_q   <= overflow_d;
      result_cnt_q <= result_cnt_d;
    end
  end

  // Storage is never reset; empty gating keeps stale contents off the output.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= ha_result_t'(bus.in_data);
    end
  end

  assign bus.out_valid  = !empty;
  assign bus.out_data   = empty ? '0 : mem_q[rd_ptr_q];
  assign bus.full       = full;
  assign bus.empty      = empty;
  assign bus.level      = level_q;
  assign bus.overflow   = overflow_q;
  assign bus.result_cnt = result_cnt_q;

`ifdef HA_RESULT_CHECK_EN
  ha_result_check #(
    .CNT_W (CNT_W)
  ) u_check (
    .clk         (clk),
    .rst         (rst),
    .chk_valid_i (push),
    .result_i    (ha_result_t'(bus.in_data)),
    .err_o       (bus.err),
    .err_cnt_o   (bus.err_cnt)
  );
`else
  assign bus.err     = 1'b0;
  assign bus.err_cnt = '0;
`endif

endmodule

// File: tb/tb_ha_result_buffer.sv
// Directed self-checking bench for ha_result_buffer (DEPTH=8, CNT_W=16);
// checker expectations follow HA_RESULT_CHECK_EN.
module tb_ha_result_buffer;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ha_result_buffer_if #(.DEPTH(8), .CNT_W(16)) bus ();

  ha_result_buffer #(.DEPTH(8), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Fill pattern: (a,b) = (1,0),(0,1),(1,1),(0,0) repeated, encoded {s,c,b,a}.
  logic [3:0] fill_tab [8] = '{4'b1001, 4'b1010, 4'b0111, 4'b0000,
                               4'b1001, 4'b1010, 4'b0111, 4'b0000};
  logic [3:0] order_tab [4] = '{4'b0000, 4'b1001, 4'b1010, 4'b0111};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 4'b0;
    bus.out_ready = 1'b0;
    repeat (2) tick();
    chk("rst_level",    32'(bus.level), 32'd0);
    chk("rst_empty",    32'(bus.empty), 32'd1);
    chk("rst_full",     32'(bus.full), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    chk("rst_cnt",      32'(bus.result_cnt), 32'd0);
    chk("rst_err",      32'(bus.err), 32'd0);
    chk("rst_err_cnt",  32'(bus.err_cnt), 32'd0);
    rst = 1'b0;
    tick();

    // Ordering
    bus.in_valid = 1'b1;
    bus.in_data  = order_tab[0];
    chk("empty_no_valid", 32'(bus.out_valid), 32'd0);
    tick();
    chk("first_valid", 32'(bus.out_valid), 32'd1);
    chk("first_data",  32'(bus.out_data), 32'(order_tab[0]));
    chk("first_level", 32'(bus.level), 32'd1);
    for (int i = 1; i < 4; i++) begin
      bus.in_data = order_tab[i];
      tick();
    end
    bus.in_valid = 1'b0;
    chk("ord_level", 32'(bus.level), 32'd4);
    chk("ord_cnt",   32'(bus.result_cnt), 32'd4);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ord_pop%0d", i), 32'(bus.out_data), 32'(order_tab[i]));
      tick();
    end
    chk("drain_empty", 32'(bus.empty), 32'd1);
    chk("drain_data",  32'(bus.out_data), 32'd0);
    tick();
    chk("ready_on_empty_level", 32'(bus.level), 32'd0);
    bus.out_ready = 1'b0;

    // Asynchronous reset with level=5, asserted between edges
    bus.in_valid = 1'b1;
    bus.in_data  = 4'b1001;
    repeat (5) tick();
    bus.in_valid = 1'b0;
    chk("pre_arst_level", 32'(bus.level), 32'd5);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_level",     32'(bus.level), 32'd0);
    chk("arst_empty",     32'(bus.empty), 32'd1);
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_cnt",       32'(bus.result_cnt), 32'd0);
    #1;
    rst = 1'b0;
    tick();

    // Fill to DEPTH
    bus.in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_data = fill_tab[i];
      tick();
    end
    bus.in_valid = 1'b0;
    chk("fill_full",  32'(bus.full), 32'd1);
    chk("fill_level", 32'(bus.level), 32'd8);
    chk("fill_cnt",   32'(bus.result_cnt), 32'd8);
    chk("fill_ovf",   32'(bus.overflow), 32'd0);

    // Push and pop together while full
    bus.in_valid  = 1'b1;
    bus.in_data   = 4'b0111;
    bus.out_ready = 1'b1;
    chk("pp_head_old", 32'(bus.out_data), 32'(fill_tab[0]));
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("pp_level", 32'(bus.level), 32'd8);
    chk("pp_full",  32'(bus.full), 32'd1);
    chk("pp_ovf",   32'(bus.overflow), 32'd0);
    chk("pp_cnt",   32'(bus.result_cnt), 32'd9);
    chk("pp_head_new", 32'(bus.out_data), 32'(fill_tab[1]));

    // Overflow drop
    bus.in_valid = 1'b1;
    bus.in_data  = 4'b1010;
    tick();
    bus.in_valid = 1'b0;
    chk("ovf_flag",  32'(bus.overflow), 32'd1);
    chk("ovf_level", 32'(bus.level), 32'd8);
    chk("ovf_cnt",   32'(bus.result_cnt), 32'd9);
    tick();
    chk("ovf_sticky", 32'(bus.overflow), 32'd1);

    // Drain: oldest survivors first, then the entry pushed during push+pop
    bus.out_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      chk($sformatf("full_pop%0d", i), 32'(bus.out_data), 32'(fill_tab[i]));
      tick();
    end
    chk("full_pop_last", 32'(bus.out_data), 32'h7);
    tick();
    chk("full_drain_empty", 32'(bus.empty), 32'd1);
    bus.out_ready = 1'b0;

    // Result checker
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    bus.in_valid = 1'b1;
    bus.in_data  = 4'b0001;
    tick();
    bus.in_data  = 4'b0111;
`ifdef HA_RESULT_CHECK_EN
    chk("chk_err",     32'(bus.err), 32'd1);
    chk("chk_err_cnt", 32'(bus.err_cnt), 32'd1);
`else
    chk("chk_err",     32'(bus.err), 32'd0);
    chk("chk_err_cnt", 32'(bus.err_cnt), 32'd0);
`endif
    chk("chk_entry_kept", 32'(bus.out_data), 32'h1);
    tick();
    bus.in_valid = 1'b0;
`ifdef HA_RESULT_CHECK_EN
    chk("chk_good_err_cnt", 32'(bus.err_cnt), 32'd1);
    chk("chk_good_err",     32'(bus.err), 32'd1);
`else
    chk("chk_good_err_cnt", 32'(bus.err_cnt), 32'd0);
    chk("chk_good_err",     32'(bus.err), 32'd0);
`endif
    chk("chk_level", 32'(bus.level), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
